rr_arb8_sel: RTL and testbench



---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick8.sv | 38 +++
 rtl/rr_arb8_sel.sv | 96 +++++++++
 tb/tb_rr_arb8_sel.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the eight-way round-robin arbiter slice.
//   NUM_REQ     : number of requesters (8)
//   IDX_W       : width of a requester index / priority pointer (3)
//   HOLD_W      : width of the grant hold counter (8)
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// -----------------------------------------------------------------------------
// rr_pick8
// Combinational rotating-priority encoder. Scans the request vector starting
// at the priority pointer and wrapping modulo 8, returning the first set bit.
// Ports:
//   req [7:0] : request vector, bit i = requester i
//   ptr [2:0] : index that currently has highest priority
//   any       : at least one request bit is set
//   idx [2:0] : first requesting index at or after ptr (mod 8); 0 when !any
// -----------------------------------------------------------------------------
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // The 3-bit add wraps naturally, so cand walks ptr, ptr+1, ..., ptr-1.
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb8_sel.sv
// -----------------------------------------------------------------------------
// rr_arb8_sel
// Eight-way round-robin arbiter producing a registered 3-bit grant index plus
// valid, intended to drive the select of a 3-to-8 one-hot decoder. A grant is
// held until the owner pulses done or, when MAX_HOLD is non-zero, until it has
// been held for MAX_HOLD cycles. Priority then rotates to the index after the
// released owner.
// Parameters:
//   MAX_HOLD  : cycles before a forced release (0 disables, legal 0..255)
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req [7:0] : request vector, sampled only while idle
//   done      : release pulse from the current owner, ignored while idle
//   gnt_valid : a grant is active
//   gnt_idx   : granted requester index (kept after release)
//   timeout   : one-cycle pulse coincident with a forced release
// -----------------------------------------------------------------------------
module rr_arb8_sel
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               timeout
);

    // With MAX_HOLD = 0 the limit value is meaningless; TIMEOUT_EN masks it.
    localparam logic              TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Single FSM block: all outputs are registered here. done takes priority
    // over the hold limit, so a coincident done suppresses the timeout pulse.
    // The hold counter saturates so a disabled timeout never wraps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_valid <= 1'b0;
            gnt_idx   <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (done) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                    end else if (TIMEOUT_EN && (hold_cnt == HOLD_LAST)) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + IDX_W'(1);
                        timeout   <= 1'b1;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arb8_sel.sv
// -----------------------------------------------------------------------------
// tb_rr_arb8_sel
// Scoreboard bench for rr_arb8_sel. The stimulus process steps a behavioural
// model of the arbiter and queues every expected grant/release event with the
// clock edge it should appear after; a monitor process compares each output
// change of the DUT against the queue. A second instance with MAX_HOLD = 0
// covers the disabled-timeout case.
// -----------------------------------------------------------------------------
module tb_rr_arb8_sel;

    localparam int H = 4;

    typedef struct {
        int         cyc;
        bit         valid;
        logic [2:0] idx;
        bit         to;
    } event_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       timeout;

    logic [7:0] req_nh;
    logic       done_nh;
    logic       gnt_valid_nh;
    logic [2:0] gnt_idx_nh;
    logic       timeout_nh;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    event_t exp_q[$];
    int     obs_grants[$];
    int     exp_seq[$];
    int     obs_timeouts = 0;

    bit     m_busy;
    int     m_owner;
    int     m_ptr;
    int     m_held;

    bit     mon_prev;
    event_t mon_e;

    rr_arb8_sel #(.MAX_HOLD(H)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    rr_arb8_sel #(.MAX_HOLD(0)) u_nohold (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_nh),
        .done      (done_nh),
        .gnt_valid (gnt_valid_nh),
        .gnt_idx   (gnt_idx_nh),
        .timeout   (timeout_nh)
    );

    // Free-running clock and edge counter used to timestamp expected events
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pass/fail bookkeeping for a single scalar comparison
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Model of the arbiter: idle until some request exists, pick the first
    // requester at or after the pointer, keep it for at most H cycles
    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
        exp_q.delete();
    endfunction

    function automatic void model_release(input bit to);
        event_t e;
        m_busy  = 1'b0;
        m_ptr   = (m_owner + 1) % 8;
        e.cyc   = cyc + 1;
        e.valid = 1'b0;
        e.idx   = 3'(m_owner);
        e.to    = to;
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(input logic [7:0] r, input bit d);
        event_t e;
        bit     found;
        if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (!found && r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    found   = 1'b1;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_held  = 1;
                e.cyc   = cyc + 1;
                e.valid = 1'b1;
                e.idx   = 3'(m_owner);
                e.to    = 1'b0;
                exp_q.push_back(e);
            end
        end else if (d) begin
            model_release(1'b0);
        end else if (H != 0 && m_held == H) begin
            model_release(1'b1);
        end else begin
            m_held++;
        end
    endfunction

    // Drive one cycle of inputs just after a rising edge and predict the next edge
    task automatic applyStimulus(input logic [7:0] r, input bit d);
        @(posedge clk);
        #1;
        req  = r;
        done = d;
        model_step(r, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        model_reset();
        obs_grants.delete();
        obs_timeouts = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Let the last driven edge happen and be consumed by the monitor
    task automatic finish_test();
        applyStimulus(8'h00, 1'b0);
        @(negedge clk);
        #1;
    endtask

    task automatic check_seq(input string name);
        checkOutput({name, " grant count"}, obs_grants.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < obs_grants.size(); i++)
            checkOutput($sformatf("%s grant %0d", name, i), obs_grants[i], exp_seq[i]);
        exp_seq.delete();
    endtask

    // Monitor: every change of gnt_valid, or any timeout pulse, must match the
    // oldest queued event stamped with the current edge
    initial begin
        mon_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = 1'b0;
                continue;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("[TB] FAIL missed event: cycle %0d expected valid=%0d idx=%0d timeout=%0d, got no output change",
                         mon_e.cyc, mon_e.valid, mon_e.idx, mon_e.to);
            end
            if (gnt_valid !== mon_prev || timeout !== 1'b0) begin
                n_checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected event: cycle %0d got valid=%0d idx=%0d timeout=%0d, expected no change",
                             cyc, gnt_valid, gnt_idx, timeout);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (gnt_valid !== mon_e.valid || gnt_idx !== mon_e.idx || timeout !== mon_e.to) begin
                        n_fail++;
                        $display("[TB] FAIL event: cycle %0d got valid=%0d idx=%0d timeout=%0d, expected valid=%0d idx=%0d timeout=%0d",
                                 cyc, gnt_valid, gnt_idx, timeout, mon_e.valid, mon_e.idx, mon_e.to);
                    end
                end
                if (gnt_valid === 1'b1 && !mon_prev) obs_grants.push_back(int'(gnt_idx));
                if (timeout === 1'b1) obs_timeouts++;
            end
            mon_prev = gnt_valid;
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        int         bad;
        int         mode;
        logic [7:0] r;
        bit         d;

        rst_n   = 1'b0;
        req     = '0;
        done    = 1'b0;
        req_nh  = '0;
        done_nh = 1'b0;
        model_reset();

        // Reset state and a single requester released by done
        do_reset();
        checkOutput("reset gnt_valid", int'(gnt_valid), 0);
        checkOutput("reset gnt_idx", int'(gnt_idx), 0);
        checkOutput("reset timeout", int'(timeout), 0);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h04, 1'b0);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'h00, 1'b1);
        finish_test();
        exp_seq.push_back(2);
        exp_seq.push_back(3);
        check_seq("single");

        // Full rotation with done on every grant
        do_reset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'hFF, 1'b0);
            applyStimulus(8'hFF, 1'b1);
        end
        finish_test();
        for (int i = 0; i < 9; i++) exp_seq.push_back(i % 8);
        check_seq("rotation");

        // Pointer wrap and skip over empty requesters
        do_reset();
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h21, 1'b0);
        applyStimulus(8'h21, 1'b1);
        applyStimulus(8'h21, 1'b0);
        applyStimulus(8'h21, 1'b1);
        finish_test();
        exp_seq.push_back(5);
        exp_seq.push_back(0);
        exp_seq.push_back(5);
        check_seq("wrap");

        // Forced release by the hold limit, regranted after the bubble
        do_reset();
        repeat (12) applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h00, 1'b1);
        finish_test();
        exp_seq.push_back(4);
        exp_seq.push_back(4);
        exp_seq.push_back(4);
        check_seq("timeout");
        checkOutput("timeout pulse count", obs_timeouts, 2);

        // done colliding with the limit, done while idle, owner dropping req
        do_reset();
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h08, 1'b0);
        applyStimulus(8'h00, 1'b1);
        finish_test();
        exp_seq.push_back(3);
        exp_seq.push_back(3);
        check_seq("collision");
        checkOutput("collision timeout count", obs_timeouts, 0);

        // Asynchronous reset in the middle of a grant to requester 5
        do_reset();
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h00, 1'b0);
        @(negedge clk);
        #2;
        checkOutput("pre-reset gnt_valid", int'(gnt_valid), 1);
        checkOutput("pre-reset gnt_idx", int'(gnt_idx), 5);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset gnt_valid", int'(gnt_valid), 0);
        checkOutput("async reset gnt_idx", int'(gnt_idx), 0);
        checkOutput("async reset timeout", int'(timeout), 0);
        model_reset();
        obs_grants.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'hA0, 1'b0);
        applyStimulus(8'h00, 1'b1);
        finish_test();
        exp_seq.push_back(5);
        check_seq("after reset");

        // Timeout disabled: grant held for 300 cycles without a pulse
        @(posedge clk);
        #1;
        req_nh = 8'h10;
        @(posedge clk);
        #1;
        req_nh = 8'h00;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (gnt_valid_nh !== 1'b1 || timeout_nh !== 1'b0 || gnt_idx_nh !== 3'd4) bad++;
        end
        checkOutput("no-timeout held cycles in error", bad, 0);
        @(posedge clk);
        #1;
        done_nh = 1'b1;
        @(posedge clk);
        #1;
        done_nh = 1'b0;
        @(negedge clk);
        checkOutput("no-timeout release gnt_valid", int'(gnt_valid_nh), 0);
        checkOutput("no-timeout release timeout", int'(timeout_nh), 0);
        checkOutput("no-timeout release gnt_idx", int'(gnt_idx_nh), 4);

        // Randomized traffic with mixed request densities
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       r = 8'h00;
                1:       r = 8'(1 << $urandom_range(0, 7));
                2:       r = 8'($urandom);
                default: r = 8'hFF;
            endcase
            d = ($urandom_range(0, 3) == 0);
            applyStimulus(r, d);
        end
        applyStimulus(8'h00, 1'b1);
        finish_test();
        checkOutput("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
